// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package wb_arb_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;

    // x0 is hardwired to zero, so writes to it are dropped.
    localparam int REG_ZERO = 0;

    // Enough for STARVE_LIMIT up to 15.
    localparam int STARVE_W = 4;
    typedef logic [STARVE_W-1:0] starve_cnt_t;

    typedef enum logic {
        PIPE_PRI = 1'b0,
        MC_FORCE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/wb_fwd_mux.sv
// Write-before-read bypass for one decode read port (built only with WB_ARB_FWD_EN).
// Latency: combinational.
// Backpressure: none; pure mux on the registered write and the RF read data.
`ifdef WB_ARB_FWD_EN
module wb_fwd_mux
    import wb_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic [DATA_W-1:0] rd_data
);

    // Forward the in-flight write when it targets the register being read (never x0).
    always_comb begin
        rd_data = rf_rd_data;
        if (wr_en && (wr_addr == rd_addr) && (rd_addr != ADDR_W'(REG_ZERO))) begin
            rd_data = wr_data;
        end
    end

endmodule
`endif

// File: rtl/wb_port_arbiter.sv
// Shares the RF write port: pipeline writeback has priority, a starvation guard forces mc results.
// Latency: 1 cycle from grant to rf_we/rf_addr/rf_data; mc_ready/pipe_stall are combinational.
// Backpressure: mc waits on mc_ready; the pipeline is stalled only in the forced-mc cycle.
// Optional macro WB_ARB_FWD_EN adds the decode read-port bypass (rs1/rs2).
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 4            // legal range 1..15
) (
`ifdef WB_ARB_FWD_EN
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic [DATA_W-1:0] rf_rs1_data,
    input  logic [DATA_W-1:0] rf_rs2_data,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
`endif
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_data,
    output logic              pipe_stall,
    input  logic              mc_valid,
    input  logic [ADDR_W-1:0] mc_addr,
    input  logic [DATA_W-1:0] mc_data,
    output logic              mc_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data
);

    localparam starve_cnt_t LIMIT_M1 = starve_cnt_t'(STARVE_LIMIT - 1);

    arb_state_t  state, state_nxt;
    starve_cnt_t starve_cnt, starve_cnt_nxt;
    logic        pipe_req;
    logic        grant_pipe;
    logic        grant_mc;

    // A write to x0 is architecturally a no-op, so it never competes for the port.
    assign pipe_req = pipe_we && (pipe_addr != ADDR_W'(REG_ZERO));

    // State register and starvation counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= PIPE_PRI;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // Next state: count cycles the mc result loses, force it through after STARVE_LIMIT losses.
    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        case (state)
            PIPE_PRI: begin
                if (mc_valid && !mc_ready) begin
                    if (starve_cnt == LIMIT_M1) begin
                        state_nxt      = MC_FORCE;
                        starve_cnt_nxt = '0;
                    end else begin
                        starve_cnt_nxt = starve_cnt + starve_cnt_t'(1);
                    end
                end else begin
                    starve_cnt_nxt = '0;
                end
            end
            MC_FORCE: begin
                // Either the forced transfer happens now, or mc went idle: both end the force.
                state_nxt      = PIPE_PRI;
                starve_cnt_nxt = '0;
            end
            default: begin
                state_nxt      = PIPE_PRI;
                starve_cnt_nxt = '0;
            end
        endcase
    end

    // Outputs and grants; everything is held off while reset is asserted.
    always_comb begin
        mc_ready   = 1'b0;
        pipe_stall = 1'b0;
        grant_pipe = 1'b0;
        grant_mc   = 1'b0;
        if (!reset) begin
            case (state)
                PIPE_PRI: begin
                    if (pipe_req) begin
                        grant_pipe = 1'b1;
                    end else if (mc_valid) begin
                        mc_ready = 1'b1;
                        grant_mc = 1'b1;
                    end
                end
                MC_FORCE: begin
                    if (mc_valid) begin
                        mc_ready   = 1'b1;
                        grant_mc   = 1'b1;
                        pipe_stall = pipe_req;
                    end else begin
                        grant_pipe = pipe_req;
                    end
                end
                default: begin
                    grant_pipe = 1'b0;
                end
            endcase
        end
    end

    // Register the winning write; an accepted mc write to x0 is consumed but not written.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
        end else begin
            rf_we <= 1'b0;
            if (grant_pipe) begin
                rf_we   <= 1'b1;
                rf_addr <= pipe_addr;
                rf_data <= pipe_data;
            end else if (grant_mc && (mc_addr != ADDR_W'(REG_ZERO))) begin
                rf_we   <= 1'b1;
                rf_addr <= mc_addr;
                rf_data <= mc_data;
            end
        end
    end

`ifdef WB_ARB_FWD_EN
    wb_fwd_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd_rs1 (
        .wr_en      (rf_we),
        .wr_addr    (rf_addr),
        .wr_data    (rf_data),
        .rd_addr    (rs1_addr),
        .rf_rd_data (rf_rs1_data),
        .rd_data    (rs1_data)
    );

    wb_fwd_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd_rs2 (
        .wr_en      (rf_we),
        .wr_addr    (rf_addr),
        .wr_data    (rf_data),
        .rd_addr    (rs2_addr),
        .rf_rd_data (rf_rs2_data),
        .rd_data    (rs2_data)
    );
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed cases then randomized traffic.
// Expected RF writes are queued with their due cycle; a monitor pops and compares.
// Forwarding ports are exercised too when WB_ARB_FWD_EN is defined.
module tb_wb_port_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pipe_we = 1'b0;
    logic [AW-1:0] pipe_addr = '0;
    logic [DW-1:0] pipe_data = '0;
    logic          pipe_stall;
    logic          mc_valid = 1'b0;
    logic [AW-1:0] mc_addr = '0;
    logic [DW-1:0] mc_data = '0;
    logic          mc_ready;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
`ifdef WB_ARB_FWD_EN
    logic [AW-1:0] rs1_addr = '0;
    logic [AW-1:0] rs2_addr = '0;
    logic [DW-1:0] rf_rs1_data = '0;
    logic [DW-1:0] rf_rs2_data = '0;
    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs2_data;
`endif

    wb_port_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
`ifdef WB_ARB_FWD_EN
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rf_rs1_data (rf_rs1_data),
        .rf_rs2_data (rf_rs2_data),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
`endif
        .clk        (clk),
        .reset      (reset),
        .pipe_we    (pipe_we),
        .pipe_addr  (pipe_addr),
        .pipe_data  (pipe_data),
        .pipe_stall (pipe_stall),
        .mc_valid   (mc_valid),
        .mc_addr    (mc_addr),
        .mc_data    (mc_data),
        .mc_ready   (mc_ready),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int            due;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  passes = 0;

    // Reference state: how many consecutive cycles the pending mc request has lost,
    // and whether each requester is obliged to hold its request next cycle.
    int waited    = 0;
    bit pipe_hold = 1'b0;
    bit mc_hold   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock of stimulus plus the reference decision for that cycle.
    task automatic step(input logic rst, input logic pw, input logic [AW-1:0] pa,
                        input logic [DW-1:0] pd, input logic mv, input logic [AW-1:0] ma,
                        input logic [DW-1:0] md);
        bit preq, mc_win, pipe_win, stall;
        @(posedge clk);
        #1;
        reset = rst;
        if (!pipe_hold) begin
            pipe_we   = pw;
            pipe_addr = pa;
            pipe_data = pd;
        end
        if (!mc_hold) begin
            mc_valid = mv;
            mc_addr  = ma;
            mc_data  = md;
        end
`ifdef WB_ARB_FWD_EN
        rs1_addr    = AW'($urandom_range(0, 7));
        rs2_addr    = AW'($urandom_range(0, 7));
        rf_rs1_data = $urandom;
        rf_rs2_data = $urandom;
`endif
        @(negedge clk);
        preq     = pipe_we && (pipe_addr != 0);
        mc_win   = 1'b0;
        pipe_win = 1'b0;
        stall    = 1'b0;
        if (!rst) begin
            // mc gets the port if the pipeline is idle, or once it has lost LIMIT times.
            if (mc_valid && (!preq || waited >= LIMIT)) begin
                mc_win = 1'b1;
                stall  = preq;
            end else if (preq) begin
                pipe_win = 1'b1;
            end
        end
        chk("mc_ready", mc_ready, mc_win);
        chk("pipe_stall", pipe_stall, stall);
        if (pipe_win) exp_q.push_back('{cyc + 1, pipe_addr, pipe_data});
        if (mc_win && mc_addr != 0) exp_q.push_back('{cyc + 1, mc_addr, mc_data});
        if (rst || !mc_valid || mc_win) waited = 0;
        else waited++;
        pipe_hold = !rst && stall;
        mc_hold   = !rst && mc_valid && !mc_win;
    endtask

    // Monitor: every cycle, the RF port must show exactly the write that is due now.
    initial begin
        wr_t e;
        bit  exp_we;
        forever begin
            @(negedge clk);
            exp_we = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("rf_we", rf_we, exp_we);
            if (exp_we) begin
                e = exp_q.pop_front();
                if (rf_we) begin
                    chk("rf_addr", rf_addr, e.addr);
                    chk("rf_data", rf_data, e.data);
                end
            end
`ifdef WB_ARB_FWD_EN
            chk("rs1_data", rs1_data,
                (exp_we && e.addr == rs1_addr && rs1_addr != 0) ? e.data : rf_rs1_data);
            chk("rs2_data", rs2_data,
                (exp_we && e.addr == rs2_addr && rs2_addr != 0) ? e.data : rf_rs2_data);
`endif
        end
    end

    initial begin
        // Reset with both requesters active: nothing may be granted.
        step(1, 1, 5'd3, 32'h1111, 1, 5'd4, 32'h2222);
        step(1, 1, 5'd3, 32'h1111, 1, 5'd4, 32'h2222);
        chk("reset_rf_addr", rf_addr, 0);
        chk("reset_rf_data", rf_data, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Pipeline only.
        step(0, 1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Multi-cycle only.
        step(0, 0, 0, 0, 1, 5'd9, 32'h1234);
        step(0, 0, 0, 0, 0, 0, 0);

        // Starvation: continuous pipeline writes, mc forced on its fifth cycle.
        for (int i = 0; i < 7; i++)
            step(0, 1, AW'(i + 1), 32'hA000 + i, (i < 5), 5'd12, 32'h5555);
        step(0, 0, 0, 0, 0, 0, 0);

        // x0 pipeline write does not block mc; mc write to x0 is accepted but dropped.
        step(0, 1, 5'd0, 32'hBAD0, 1, 5'd17, 32'h7777);
        step(0, 0, 0, 0, 1, 5'd0, 32'hABC);
        step(0, 0, 0, 0, 0, 0, 0);

        // Reset in the cycle an mc transfer would be granted.
        step(0, 1, 5'd4, 32'h4444, 1, 5'd9, 32'h9999);
        step(1, 0, 0, 0, 1, 5'd9, 32'h9999);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 9) < 7), AW'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 9) < 4), AW'($urandom_range(0, 7)), $urandom);

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
